// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file.
//   RNONE / RRSP : Y86 register index constants (no-register marker, stack pointer)
//   DUMP_*       : state encodings of the register dump engine
package regfile_mp_pkg;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam logic [1:0] DUMP_IDLE = 2'd0;
  localparam logic [1:0] DUMP_SCAN = 2'd1;
  localparam logic [1:0] DUMP_EMIT = 2'd2;
  localparam logic [1:0] DUMP_DONE = 2'd3;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Dump engine: walks the register array one index per cycle and emits every
// non-zero register as an (idx, val) beat.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   i_start       : start pulse, honoured only when idle
//   i_ready       : beat consumer ready
//   i_scan_val    : value of register o_scan_idx (from the parent's read port)
//   o_scan_idx    : index currently being scanned
//   o_idx, o_val  : captured beat, held stable while waiting for ready
//   o_state       : current FSM state (DUMP_* encoding); the parent decodes
//                   valid/busy/done from it and it is also the debug view
// Handshake: a beat transfers on a rising edge where valid & ready are both 1;
// idx/val do not change while valid is high and ready is low.
module regfile_dump_fsm
  import regfile_mp_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 15,
  parameter int AW    = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            i_start,
  input  logic            i_ready,
  input  logic [XLEN-1:0] i_scan_val,
  output logic [AW-1:0]   o_scan_idx,
  output logic [AW-1:0]   o_idx,
  output logic [XLEN-1:0] o_val,
  output logic [1:0]      o_state
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  logic [1:0]      r_state;
  logic [AW-1:0]   r_ptr;
  logic [AW-1:0]   r_idx;
  logic [XLEN-1:0] r_val;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= DUMP_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_val   <= '0;
    end else begin
      case (r_state)
        DUMP_IDLE: begin
          if (i_start) begin
            r_ptr   <= '0;
            r_state <= DUMP_SCAN;
          end
        end
        DUMP_SCAN: begin
          if (i_scan_val != '0) begin
            // Beat data is frozen here; later writes to this register are not re-emitted.
            r_idx   <= r_ptr;
            r_val   <= i_scan_val;
            r_state <= DUMP_EMIT;
          end else if (r_ptr == LAST) begin
            r_state <= DUMP_DONE;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        DUMP_EMIT: begin
          // Always return through SCAN, so valid drops for at least one cycle between beats.
          if (i_ready) begin
            if (r_ptr == LAST) begin
              r_state <= DUMP_DONE;
            end else begin
              r_ptr   <= r_ptr + 1'b1;
              r_state <= DUMP_SCAN;
            end
          end
        end
        default: r_state <= DUMP_IDLE;
      endcase
    end
  end

  assign o_scan_idx = r_ptr;
  assign o_idx      = r_idx;
  assign o_val      = r_val;
  assign o_state    = r_state;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file for the decode stage with a hardware dump engine.
//   clk_i, rst_i          : clock, synchronous active-high reset (clears all registers)
//   rd_idx_i / rd_val_o   : NRD combinational read ports, port k at [k*AW +: AW] / [k*XLEN +: XLEN]
//   dstE_i/valE_i         : E write port (RNONE or index >= NREGS means no write)
//   dstM_i/valM_i         : M write port; wins over E on the same index
//   dump_start_i          : start a dump (ignored while a dump is running)
//   dump_valid_o/ready_i  : dump beat handshake, beat = (dump_idx_o, dump_val_o)
//   dump_busy_o           : dump in progress
//   dump_done_o           : one-cycle pulse at the end of a dump
// Optional feature macro REGFILE_WBYPASS_EN: when defined, reads (including the
// dump scan) see same-cycle write data, M before E. When undefined, reads see
// stored contents only.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 15,
  parameter int AW    = 4,
  parameter int NRD   = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NRD*AW-1:0]   rd_idx_i,
  output logic [NRD*XLEN-1:0] rd_val_o,
  input  logic [AW-1:0]       dstE_i,
  input  logic [XLEN-1:0]     valE_i,
  input  logic [AW-1:0]       dstM_i,
  input  logic [XLEN-1:0]     valM_i,
  input  logic                dump_start_i,
  output logic                dump_valid_o,
  input  logic                dump_ready_i,
  output logic [AW-1:0]       dump_idx_o,
  output logic [XLEN-1:0]     dump_val_o,
  output logic                dump_busy_o,
  output logic                dump_done_o
);

  localparam logic [AW:0]   NREGS_W = (AW + 1)'(NREGS);
  localparam logic [AW-1:0] IDX_NONE = {AW{1'b1}};

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_e_en;
  logic            w_m_en;
  logic [AW-1:0]   w_scan_idx;
  logic [XLEN-1:0] w_scan_val;
  logic [1:0]      w_dump_state;

  assign w_e_en = ({1'b0, dstE_i} < NREGS_W) && (dstE_i != IDX_NONE);
  assign w_m_en = ({1'b0, dstM_i} < NREGS_W) && (dstM_i != IDX_NONE);

  // M is written last so it overrides E on the same index (popq %rsp).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if (w_e_en) r_regs[dstE_i] <= valE_i;
      if (w_m_en) r_regs[dstM_i] <= valM_i;
    end
  end

  // Ports 0..NRD-1 are the external read ports; port NRD feeds the dump scan.
  for (genvar k = 0; k <= NRD; k++) begin : g_rd
    logic [AW-1:0]   w_idx;
    logic [XLEN-1:0] w_val;
    logic            w_ok;

    if (k < NRD) begin : g_ext
      assign w_idx = rd_idx_i[k*AW +: AW];
      assign rd_val_o[k*XLEN +: XLEN] = w_val;
    end else begin : g_scan
      assign w_idx      = w_scan_idx;
      assign w_scan_val = w_val;
    end

    assign w_ok = ({1'b0, w_idx} < NREGS_W) && (w_idx != IDX_NONE);

    always_comb begin
      w_val = '0;
      if (w_ok) begin
        w_val = r_regs[w_idx];
`ifdef REGFILE_WBYPASS_EN
        if (w_e_en && (dstE_i == w_idx)) w_val = valE_i;
        if (w_m_en && (dstM_i == w_idx)) w_val = valM_i;
`endif
      end
    end
  end

  regfile_dump_fsm #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_dump (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_start    (dump_start_i),
    .i_ready    (dump_ready_i),
    .i_scan_val (w_scan_val),
    .o_scan_idx (w_scan_idx),
    .o_idx      (dump_idx_o),
    .o_val      (dump_val_o),
    .o_state    (w_dump_state)
  );

  assign dump_valid_o = (w_dump_state == DUMP_EMIT);
  assign dump_busy_o  = (w_dump_state == DUMP_SCAN) || (w_dump_state == DUMP_EMIT);
  assign dump_done_o  = (w_dump_state == DUMP_DONE);

endmodule
